irq_pending_capture: RTL and testbench

//   Upstream request-capture stage for the 16-line priority encoder. Synchronises 16 raw

---
 rtl/irq_pending_capture.sv | 163 ++++++++++++++++
 tb/tb_irq_pending_capture.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_capture.sv
// irq_pending_capture
// Request-capture front end for the 16-line priority encoder. Raw request levels are
// synchronised and edge-detected. Rising edges are latched into a sticky pending
// register that the encoder sees through the mask. An acknowledge carrying the
// encoder's index clears the serviced bit. A rise that lands on a line which is
// already pending, and is not being serviced in the same cycle, is reported as an
// overflow. The first overflowing index is kept until the flag is cleared.

module irq_pending_capture #(
    parameter int N_REQ   = 16,
    parameter int SYNC_ST = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask_in,
    output logic [N_REQ-1:0] pending_out,
    input  logic [7:0]       enc_idx,
    input  logic             ack_in,
    output logic             irq_out,
    output logic             ovf_out,
    output logic [3:0]       ovf_idx,
    input  logic             ovf_clr
);

    // Returns the index of the highest set bit. Used so that the highest line wins
    // when several lines overflow in the same cycle.
    function automatic logic [3:0] msb_index(input logic [N_REQ-1:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = i[3:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Synchroniser chain: stage 0 samples the raw pins and stage SYNC_ST-1 is the
    // settled level.
    logic [SYNC_ST-1:0][N_REQ-1:0] sync_q;
    logic [SYNC_ST-1:0][N_REQ-1:0] sync_d;

    // Edge history. It follows the settled level every cycle, even with ena low, so
    // that edges seen while disabled are consumed and never replayed.
    logic [N_REQ-1:0] hist_q;
    logic [N_REQ-1:0] hist_d;

    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] pending_d;

    logic             irq_q;
    logic             irq_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [3:0]       ovf_idx_q;
    logic [3:0]       ovf_idx_d;

    logic [N_REQ-1:0] s_last_s;
    logic [N_REQ-1:0] rise_s;
    logic             ack_hit_s;
    logic [N_REQ-1:0] ack_vec_s;
    logic [N_REQ-1:0] ovf_evt_s;

    // Shift the raw request levels one stage deeper into the synchroniser.
    always_comb begin
        sync_d = {sync_q[SYNC_ST-2:0], req_in};
    end

    // Edge detection on the settled level.
    always_comb begin
        s_last_s = sync_q[SYNC_ST-1];
        hist_d   = s_last_s;
        rise_s   = s_last_s & ~hist_q;
    end

    // Decode the acknowledge. An index with a non-zero upper nibble (including the
    // 8'hF0 "none" code) is ignored entirely.
    always_comb begin
        ack_hit_s = ack_in & ena & (enc_idx[7:4] == 4'd0);
        ack_vec_s = {N_REQ{1'b0}};
        if (ack_hit_s) begin
            ack_vec_s[enc_idx[3:0]] = 1'b1;
        end else begin
            ack_vec_s = {N_REQ{1'b0}};
        end
    end

    // Compute the next pending vector. A new rise overrides a same-cycle clear, so
    // a fresh request is never lost to the acknowledge of its predecessor.
    always_comb begin
        pending_d = pending_q;
        ovf_evt_s = {N_REQ{1'b0}};
        if (ena) begin
            pending_d = (pending_q & ~ack_vec_s) | rise_s;
            ovf_evt_s = rise_s & pending_q & ~ack_vec_s;
        end else begin
            pending_d = pending_q;
            ovf_evt_s = {N_REQ{1'b0}};
        end
    end

    // Compute the next overflow flag and index. The first index is kept while the
    // flag is up. A clear arriving together with a new overflow yields to the new
    // overflow, and the index is reloaded from that event.
    always_comb begin
        ovf_d     = ovf_q;
        ovf_idx_d = ovf_idx_q;
        if (ena) begin
            if (|ovf_evt_s) begin
                ovf_d = 1'b1;
                if (!ovf_q || ovf_clr) begin
                    ovf_idx_d = msb_index(ovf_evt_s);
                end else begin
                    ovf_idx_d = ovf_idx_q;
                end
            end else if (ovf_clr) begin
                ovf_d     = 1'b0;
                ovf_idx_d = 4'd0;
            end else begin
                ovf_d     = ovf_q;
                ovf_idx_d = ovf_idx_q;
            end
        end else begin
            ovf_d     = ovf_q;
            ovf_idx_d = ovf_idx_q;
        end
    end

    // The interrupt line follows the masked pending vector, registered one cycle later.
    always_comb begin
        irq_d = |(pending_q & mask_in);
    end

    // State registers. Reset is asynchronous and clears everything, including the
    // edge history. A line held high through reset release is therefore a new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= {(SYNC_ST*N_REQ){1'b0}};
            hist_q    <= {N_REQ{1'b0}};
            pending_q <= {N_REQ{1'b0}};
            irq_q     <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_idx_q <= 4'd0;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
            ovf_idx_q <= ovf_idx_d;
        end
    end

    assign pending_out = pending_q & mask_in;
    assign irq_out     = irq_q;
    assign ovf_out     = ovf_q;
    assign ovf_idx     = ovf_idx_q;

endmodule

// File: tb/tb_irq_pending_capture.sv
// Self-checking bench for irq_pending_capture.
// The reference model treats each line's synchronised level as its raw level sampled
// SYNC_ST edges earlier, kept in a sample queue. It applies the pending, acknowledge and
// overflow rules bit by bit with plain loops. Directed scenarios come first, then a
// long run of random stimulus.

module tb_irq_pending_capture;

    localparam int SYNC_ST = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [15:0] req_in;
    logic [15:0] mask_in;
    logic [15:0] pending_out;
    logic [7:0]  enc_idx;
    logic        ack_in;
    logic        irq_out;
    logic        ovf_out;
    logic [3:0]  ovf_idx;
    logic        ovf_clr;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: values the DUT should hold after the latest edge.
    logic [15:0] m_pend;
    logic        m_irq;
    logic        m_ovf;
    logic [3:0]  m_ovf_idx;
    logic [15:0] smp[$];

    irq_pending_capture #(.N_REQ(16), .SYNC_ST(SYNC_ST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_in     (req_in),
        .mask_in    (mask_in),
        .pending_out(pending_out),
        .enc_idx    (enc_idx),
        .ack_in     (ack_in),
        .irq_out    (irq_out),
        .ovf_out    (ovf_out),
        .ovf_idx    (ovf_idx),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behaves like the downstream priority encoder: highest set bit, or 8'hF0 if none.
    function automatic logic [7:0] enc_of(input logic [15:0] v);
        logic [7:0] r;
        r = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = 8'(i);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_pend    = 16'h0;
        m_irq     = 1'b0;
        m_ovf     = 1'b0;
        m_ovf_idx = 4'd0;
        smp.delete();
        for (int i = 0; i <= SYNC_ST; i++) smp.push_back(16'h0);
    endtask

    // Advance the model across one rising edge, using the inputs as they are now.
    task automatic model_step();
        logic [15:0] lvl, prev, newp;
        logic        acked, rise, any_evt;
        int          hi;
        lvl     = smp[1];
        prev    = smp[0];
        newp    = m_pend;
        any_evt = 1'b0;
        hi      = 0;
        m_irq   = |(m_pend & mask_in);
        if (ena) begin
            for (int i = 0; i < 16; i++) begin
                rise  = lvl[i] && !prev[i];
                acked = ack_in && (enc_idx[7:4] == 4'd0) && (int'(enc_idx[3:0]) == i);
                if (rise && m_pend[i] && !acked) begin
                    any_evt = 1'b1;
                    hi = i;
                end
                if (rise) newp[i] = 1'b1;
                else if (acked) newp[i] = 1'b0;
            end
            if (any_evt) begin
                if (!m_ovf || ovf_clr) m_ovf_idx = 4'(hi);
                m_ovf = 1'b1;
            end else if (ovf_clr) begin
                m_ovf     = 1'b0;
                m_ovf_idx = 4'd0;
            end
            m_pend = newp;
        end
        smp.push_back(req_in);
        void'(smp.pop_front());
    endtask

    task automatic check_all();
        check_val("pending_out", pending_out, m_pend & mask_in);
        check_val("irq_out", {15'd0, irq_out}, {15'd0, m_irq});
        check_val("ovf_out", {15'd0, ovf_out}, {15'd0, m_ovf});
        check_val("ovf_idx", {12'd0, ovf_idx}, {12'd0, m_ovf_idx});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pulse(input int idx, input int hi, input int lo);
        req_in[idx] = 1'b1;
        repeat (hi) tick();
        req_in[idx] = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic ack_idx(input logic [7:0] idx);
        enc_idx = idx;
        ack_in  = 1'b1;
        tick();
        ack_in  = 1'b0;
        enc_idx = 8'hF0;
    endtask

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b1;
        req_in  = 16'h0;
        mask_in = 16'hFFFF;
        enc_idx = 8'hF0;
        ack_in  = 1'b0;
        ovf_clr = 1'b0;
        model_reset();
        #22;
        check_all();
        rst_n = 1'b1;

        // Single pulse on line 3: latency, irq one edge later, then acknowledge.
        req_in[3] = 1'b1;
        repeat (3) tick();
        check_val("lat_pend3", pending_out, 16'h0008);
        req_in[3] = 1'b0;
        tick();
        check_val("lat_irq", {15'd0, irq_out}, 16'h0001);
        ack_idx(enc_of(m_pend & mask_in));
        check_val("ack3_pend", pending_out, 16'h0000);
        tick();
        check_val("ack3_irq", {15'd0, irq_out}, 16'h0000);

        // Lines 15 and 0 together, serviced in priority order, then a spurious ack.
        req_in = 16'h8001;
        repeat (3) tick();
        check_val("both_pend", pending_out, 16'h8001);
        req_in = 16'h0000;
        ack_idx(enc_of(m_pend & mask_in));
        check_val("ack15", pending_out, 16'h0001);
        ack_idx(enc_of(m_pend & mask_in));
        check_val("ack0", pending_out, 16'h0000);
        ack_idx(8'hF0);
        check_val("ack_none", pending_out, 16'h0000);
        repeat (3) tick();

        // Overflow on line 5, later overflow on line 9 keeps index 5, then clear.
        pulse(5, 3, 3);
        pulse(5, 3, 3);
        check_val("ovf5_flag", {15'd0, ovf_out}, 16'h0001);
        check_val("ovf5_idx", {12'd0, ovf_idx}, 16'h0005);
        pulse(9, 3, 3);
        pulse(9, 3, 3);
        check_val("ovf9_keep", {12'd0, ovf_idx}, 16'h0005);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_val("ovfclr_flag", {15'd0, ovf_out}, 16'h0000);
        check_val("ovfclr_idx", {12'd0, ovf_idx}, 16'h0000);
        ack_idx(8'd9);
        ack_idx(8'd5);

        // Masked line still captures; unmasking exposes it at once.
        mask_in = 16'hFFFE;
        pulse(0, 3, 3);
        check_val("mask_pend", pending_out, 16'h0000);
        check_val("mask_irq", {15'd0, irq_out}, 16'h0000);
        mask_in = 16'hFFFF;
        #1;
        check_val("unmask_pend", pending_out, 16'h0001);
        tick();
        ack_idx(8'd0);

        // A rise on line 7 in the same cycle as the ack of 7 keeps it pending, no overflow.
        pulse(7, 3, 3);
        req_in[7] = 1'b1;
        tick();
        tick();
        enc_idx = 8'd7;
        ack_in  = 1'b1;
        tick();
        ack_in  = 1'b0;
        enc_idx = 8'hF0;
        check_val("setack_pend", pending_out, 16'h0080);
        check_val("setack_ovf", {15'd0, ovf_out}, 16'h0000);
        req_in[7] = 1'b0;
        repeat (3) tick();
        ack_idx(8'd7);

        // A rise while disabled is dropped for good.
        ena = 1'b0;
        pulse(2, 3, 3);
        ena = 1'b1;
        tick();
        check_val("ena0_drop", pending_out, 16'h0000);

        // Fill all lines, reset mid-cycle, keep lines high across release.
        req_in = 16'hFFFF;
        repeat (3) tick();
        check_val("all_pend", pending_out, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_val("rst_pend", pending_out, 16'h0000);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check_val("rel_e1", pending_out, 16'h0000);
        tick();
        check_val("rel_e2", pending_out, 16'hFFFF);
        req_in = 16'h0000;
        repeat (3) tick();

        // Random phase.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 7) == 0) req_in[b] = ~req_in[b];
            end
            ena     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mask_in = 16'($urandom);
            ack_in  = ($urandom_range(0, 2) == 0);
            enc_idx = ($urandom_range(0, 4) == 0) ? 8'($urandom) : enc_of(m_pend & mask_in);
            ovf_clr = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
